// File: rtl/maze_pkg.sv
// Shared definitions for the maze memory arbiter: default widths, memory
// command encoding, FSM states and client identifiers.
package maze_pkg;

  localparam int unsigned MAZE_ADDR_W = 6;
  localparam int unsigned MAZE_DATA_W = 2;

  localparam logic MEM_CMD_READ  = 1'b1;
  localparam logic MEM_CMD_WRITE = 1'b0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  typedef enum logic {
    CL_DISP = 1'b0,
    CL_GAME = 1'b1
  } client_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: index 0 = display, index 1 = game.
// A sole requester always wins; a tie goes to the client not granted last.
module rr_arb2
  import maze_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt_c
);

  // 1 when the game client held the most recent grant
  logic last_game;

  always_comb begin
    gnt_c = req;
    if (req == 2'b11) begin
      gnt_c = last_game ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_game <= 1'b1;
    end else if (update && (|req)) begin
      last_game <= gnt_c[1];
    end
  end

endmodule

// File: rtl/maze_mem_arbiter.sv
// Arbitrates a single-port maze memory between the display reader and the
// game logic; every access is a two-cycle IDLE -> ACCESS -> IDLE round trip.
module maze_mem_arbiter
  import maze_pkg::*;
#(
  parameter int unsigned ADDR_W = MAZE_ADDR_W,
  parameter int unsigned DATA_W = MAZE_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_valid,
  input  logic              game_req,
  input  logic              game_we,
  input  logic [ADDR_W-1:0] game_addr,
  input  logic [DATA_W-1:0] game_wdata,
  output logic              game_gnt,
  output logic [DATA_W-1:0] game_rdata,
  output logic              game_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_command,
  inout  wire  [DATA_W-1:0] mem_data
);

  state_t            state_q, state_d;
  client_t           owner_q, owner_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_d;
  logic              disp_gnt_d, game_gnt_d, disp_valid_d, game_valid_d;
  logic [DATA_W-1:0] disp_rdata_d, game_rdata_d;
  logic [1:0]        arb_gnt_c;
  logic              arb_update;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({game_req, disp_req}),
    .update (arb_update),
    .gnt_c  (arb_gnt_c)
  );

  // Memory strobes come straight from registered state so they cannot glitch.
  assign mem_command = ((state_q == ST_ACCESS) && we_q) ? MEM_CMD_WRITE : MEM_CMD_READ;
  assign mem_data    = (mem_command == MEM_CMD_WRITE) ? wdata_q : {DATA_W{1'bz}};

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    addr_d       = mem_addr;
    disp_gnt_d   = 1'b0;
    game_gnt_d   = 1'b0;
    disp_valid_d = 1'b0;
    game_valid_d = 1'b0;
    disp_rdata_d = disp_rdata;
    game_rdata_d = game_rdata;
    arb_update   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (disp_req || game_req) begin
          arb_update = 1'b1;
          state_d    = ST_ACCESS;
          if (arb_gnt_c[1]) begin
            owner_d    = CL_GAME;
            addr_d     = game_addr;
            we_d       = game_we;
            wdata_d    = game_wdata;
            game_gnt_d = 1'b1;
          end else begin
            owner_d    = CL_DISP;
            addr_d     = disp_addr;
            we_d       = 1'b0;
            disp_gnt_d = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        // Requests seen here are ignored; the access always finishes now.
        state_d = ST_IDLE;
        we_d    = 1'b0;
        if (owner_q == CL_DISP) begin
          disp_rdata_d = mem_data;
          disp_valid_d = 1'b1;
        end else begin
          game_valid_d = 1'b1;
          if (!we_q) begin
            game_rdata_d = mem_data;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= CL_DISP;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      mem_addr   <= '0;
      disp_gnt   <= 1'b0;
      game_gnt   <= 1'b0;
      disp_valid <= 1'b0;
      game_valid <= 1'b0;
      disp_rdata <= '0;
      game_rdata <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      mem_addr   <= addr_d;
      disp_gnt   <= disp_gnt_d;
      game_gnt   <= game_gnt_d;
      disp_valid <= disp_valid_d;
      game_valid <= game_valid_d;
      disp_rdata <= disp_rdata_d;
      game_rdata <= game_rdata_d;
    end
  end

endmodule
